// File: rtl/div_unit.sv
// Iterative restoring divider, one shift-subtract step per clock.
// Signed (truncating) and unsigned modes; flags held with results.
module div_unit #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o,
  output logic         overflow_o
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [N-1:0]  rem;
  logic          neg_q;
  logic          neg_r;
  logic          ovf_c;

  logic          a_neg;
  logic          b_neg;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  // Operand magnitudes, trial subtract and sign fix-up.
  // The stored remainder is always below the divisor, so N bits
  // suffice between steps; the shifted trial value needs N+1.
  always_comb begin
    a_neg   = signed_i & dividend_i[N-1];
    b_neg   = signed_i & divisor_i[N-1];
    a_mag   = a_neg ? -dividend_i : dividend_i;
    b_mag   = b_neg ? -divisor_i : divisor_i;
    shifted = {rem, dvd[N-1]};
    diff    = shifted - {1'b0, dvs};
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem : rem;
  end

  // Control FSM with working registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf_c         <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            busy_o        <= 1'b1;
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b0;
            neg_q         <= a_neg ^ b_neg;
            neg_r         <= a_neg;
            ovf_c         <= signed_i &&
                             dividend_i == MIN &&
                             divisor_i == ONES;
            if (divisor_i == '0) begin
              quotient_o    <= ONES;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
              done_o        <= 1'b1;
              state         <= DONE;
            end else begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= CW'(N - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[N]) begin
            rem <= diff[N-1:0];
            dvd <= {dvd[N-2:0], 1'b1};
          end else begin
            rem <= shifted[N-1:0];
            dvd <= {dvd[N-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          quotient_o  <= q_fix;
          remainder_o <= r_fix;
          overflow_o  <= ovf_c;
          done_o      <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, corner
// sequences and random ops against an arithmetic model.
module tb_div_unit;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         signed_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_by_zero_o;
  logic         overflow_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.N(N)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .signed_i     (signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    bit           dz;
    bit           ov;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Truncating division on plain integers.
  task automatic ref_div(input bit s,
                         input logic [N-1:0] a,
                         input logic [N-1:0] b,
                         output logic [N-1:0] q,
                         output logic [N-1:0] r,
                         output bit dz,
                         output bit ov);
    int sa;
    int sb;
    dz = 0;
    ov = 0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1;
    end else begin
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      q  = N'(sa / sb);
      r  = N'(sa % sb);
      ov = s && sa == -(1 << (N - 1)) && sb == -1;
    end
  endtask

  task automatic run_op(input bit s,
                        input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        input logic [N-1:0] eq,
                        input logic [N-1:0] er,
                        input bit edz,
                        input bit eov,
                        input string tag);
    int cyc;
    bit seen;
    bit busy_ok;
    int exp_lat;
    exp_lat = (b == '0) ? 1 : N + 2;
    @(negedge clk_i);
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    dividend_i = N'($urandom);
    divisor_i  = N'($urandom);
    signed_i   = 1'($urandom);
    cyc     = 1;
    seen    = 0;
    busy_ok = 1;
    while (cyc <= 20) begin
      if (!busy_o) busy_ok = 0;
      if (done_o) begin
        seen = 1;
        break;
      end
      tick();
      cyc++;
    end
    check({tag, " latency"}, seen ? cyc : -1, exp_lat);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " quot"}, quotient_o, eq);
    check({tag, " rem"}, remainder_o, er);
    check({tag, " dz"}, div_by_zero_o, edz);
    check({tag, " ovf"}, overflow_o, eov);
    tick();
    check({tag, " idle"}, {busy_o, done_o}, 0);
    check({tag, " hold q"}, quotient_o, eq);
  endtask

  initial begin
    logic [N-1:0] mq;
    logic [N-1:0] mr;
    bit           mdz;
    bit           mov;
    bit           rs;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           done_cnt;
    int           done_at;
    logic [N-1:0] cap_q;
    logic [N-1:0] cap_r;

    tbl[0] = '{0, 13, 3, 4, 1, 0, 0};
    tbl[1] = '{1, 9, 2, 13, 15, 0, 0};
    tbl[2] = '{1, 7, 14, 13, 1, 0, 0};
    tbl[3] = '{0, 9, 0, 15, 9, 1, 0};
    tbl[4] = '{1, 9, 0, 15, 9, 1, 0};
    tbl[5] = '{1, 8, 15, 8, 0, 0, 1};
    tbl[6] = '{0, 8, 15, 0, 8, 0, 0};
    tbl[7] = '{0, 15, 4, 3, 3, 0, 0};

    rst_ni     = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) tick();
    check("reset outs",
          {busy_o, done_o, div_by_zero_o, overflow_o,
           quotient_o, remainder_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q,
             tbl[i].r, tbl[i].dz, tbl[i].ov,
             $sformatf("vec%0d", i));
    end

    // Starts during CALC and DONE must be ignored.
    @(negedge clk_i);
    signed_i   = 1'b0;
    dividend_i = 13;
    divisor_i  = 3;
    start_i    = 1'b1;
    tick();
    start_i  = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    cap_q    = '0;
    cap_r    = '0;
    for (int k = 1; k <= 8; k++) begin
      if (done_o) begin
        done_cnt++;
        done_at = k;
        cap_q   = quotient_o;
        cap_r   = remainder_o;
      end
      start_i    = (k == 2 || k == 6);
      dividend_i = 6;
      divisor_i  = 2;
      tick();
    end
    start_i = 1'b0;
    check("ign done count", done_cnt, 1);
    check("ign done at", done_at, N + 2);
    check("ign quot", cap_q, 4);
    check("ign rem", cap_r, 1);
    check("ign busy", busy_o, 0);
    run_op(0, 6, 2, 3, 0, 0, 0, "after");

    // Reset in the middle of CALC.
    @(negedge clk_i);
    signed_i   = 1'b0;
    dividend_i = 13;
    divisor_i  = 3;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check("rst mid outs",
          {busy_o, done_o, div_by_zero_o, overflow_o,
           quotient_o, remainder_o}, 0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_o) done_cnt++;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_o) done_cnt++;
    end
    check("rst no done", done_cnt, 0);
    run_op(0, 15, 4, 3, 3, 0, 0, "post rst");

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      ref_div(rs, ra, rb, mq, mr, mdz, mov);
      run_op(rs, ra, rb, mq, mr, mdz, mov,
             $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative N-bit restoring divider, signed and unsigned. It provides the multi-cycle divide counterpart to the single-cycle ADD/SUB/MOV arithmetic path.
- Sits beside the ALU in the CPU execute stage and uses one shift-subtract step per clock.
- The control unit stalls on busy_o and captures quotient_o/remainder_o on done_o.
- Flag outputs follow the ALU convention: a flag is valid with its result and is 0 otherwise.

Parameters:
- N, 4, operand/result width in bits; legal values are N >= 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
- dividend_i  input  N  dividend; sampled with start_i.
- divisor_i  input  N  divisor; sampled with start_i.
- busy_o  output  1  high from the cycle after accept until done_o inclusive.
- done_o  output  1  one-cycle pulse; results and flags valid in that cycle.
- quotient_o  output  N  quotient; held until the next accept.
- remainder_o  output  N  remainder; held until the next accept.
- div_by_zero_o  output  1  divisor was 0; held with the results.
- overflow_o  output  1  signed MIN / -1; held with the results.

Behaviour:
- Reset (rst_ni=0, immediate, any state):
  - FSM goes to IDLE.
  - busy_o, done_o, div_by_zero_o and overflow_o are 0.
  - quotient_o and remainder_o are 0.
  - Iteration counter and working registers are cleared.
  - Reset mid-operation abandons the divide; no done_o is produced.
- States:
  - IDLE: accepts a request when start_i=1.
  - CALC: iterating.
  - FIX: sign correction.
  - DONE: single-cycle done_o pulse.
- IDLE with start_i=1 (edge t0):
  - Latch the operands and signed_i.
  - Clear div_by_zero_o and overflow_o.
  - If divisor_i == 0: go to DONE. quotient_o = all ones, remainder_o = dividend_i, div_by_zero_o = 1. done_o is high in cycle t0+1.
  - Otherwise: go to CALC. Working magnitudes are |dividend| and |divisor| when signed_i=1, raw values otherwise. Partial remainder (N+1 bits) = 0, counter = N-1.
- CALC, each cycle:
  - Shift the partial remainder left and bring in the dividend MSB.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - When counter = 0, go to FIX; otherwise decrement.
  - Exactly N CALC cycles.
- FIX (signed_i=1 only; unsigned passes magnitudes through):
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative. Truncating division: the remainder takes the dividend's sign.
  - Register quotient_o and remainder_o.
  - Set overflow_o when dividend = 100..0 and divisor = 11..1. Quotient_o is then 100..0 naturally (magnitude 2^(N-1) negated) and remainder_o is 0.
  - Go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
  - busy_o falls with done_o.
  - A new start_i is accepted from IDLE the cycle after DONE, not in DONE.
- Latency:
  - done_o is asserted in cycle t0+N+2 for nonzero divisors.
  - done_o is asserted in cycle t0+1 for a zero divisor.
- start_i while busy_o=1 or in DONE is ignored; no queueing.
- Operand input changes after accept have no effect.
- Outputs hold their values across IDLE until the next accepted start (or reset).
- Width rules:
  - Partial remainder is N+1 bits so the unsigned trial subtract never loses a borrow.
  - Magnitude of MIN is taken as an unsigned N-bit value 2^(N-1).

Test Plan:
- N=4, unsigned 13/3 (1101/0011), start at t0 -> busy_o high t0+1..t0+6; done_o only at t0+6; quotient_o=0100, remainder_o=0001; flags 0.
- N=4, signed -7/2 (1001/0010) -> quotient_o=1101 (-3), remainder_o=1111 (-1); signed 7/-2 -> quotient_o=1101, remainder_o=0001; flags 0.
- N=4, 9/0 (1001/0000), either signedness -> done_o at t0+1; quotient_o=1111, remainder_o=1001, div_by_zero_o=1, overflow_o=0.
- N=4, signed -8/-1 (1000/1111) -> quotient_o=1000, remainder_o=0000, overflow_o=1; same operands unsigned (8/15) -> quotient_o=0000, remainder_o=1000, overflow_o=0.
- Start 13/3, pulse start_i with 6/2 at t0+3 and in the DONE cycle -> single done_o with 13/3 results. Start 6/2 at t0+7 -> accepted; quotient_o=0011, remainder_o=0000; flags from the previous op cleared.
- Start 13/3, drop rst_ni mid-CALC at t0+3 -> all outputs 0 immediately, no done_o. After release, start 15/4 -> quotient_o=0011, remainder_o=0011 at N+2 latency.
